// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use stall, redirect flush, drain/halt handshake.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_nop,
  output logic             id_ex_we,
  output logic             id_ex_nop,
  output logic             ex_mem_nop,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic       lu_s;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  always_comb begin
    lu_s = ex_is_load && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // State and down-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; redirect beats load-use beats halt/drain.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (ex_redirect) begin
          if (FLUSH_CYCLES > 0) begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = FLUSH_RELOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (lu_s) begin
          state_nxt_s = RUN;
        end else if (halt_req) begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = DRAIN_RELOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          cnt_nxt_s = FLUSH_RELOAD;
        end else if (cnt_r == 3'd0) begin
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      DRAIN: begin
        if (ex_redirect) begin
          cnt_nxt_s = DRAIN_RELOAD;
        end else if (lu_s) begin
          cnt_nxt_s = cnt_r;
        end else if (!halt_req) begin
          state_nxt_s = RUN;
        end else if (cnt_r == 3'd0) begin
          state_nxt_s = HALTED;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      HALTED: begin
        if (!halt_req) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Mealy enable/nop outputs so hazards act in the cycle they are seen.
  always_comb begin
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    id_ex_we   = 1'b1;
    if_id_nop  = 1'b0;
    id_ex_nop  = 1'b0;
    ex_mem_nop = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      if_id_nop  = 1'b1;
      id_ex_nop  = 1'b1;
      ex_mem_nop = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_redirect) begin
            if_id_nop = 1'b1;
            id_ex_nop = 1'b1;
          end else if (lu_s) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_nop = 1'b1;
          end else if (halt_req) begin
            pc_we     = 1'b0;
            if_id_nop = 1'b1;
          end else begin
            pc_we = 1'b1;
          end
        end
        FLUSH: begin
          if_id_nop = 1'b1;
          id_ex_nop = 1'b1;
        end
        DRAIN: begin
          if (ex_redirect) begin
            if_id_nop = 1'b1;
            id_ex_nop = 1'b1;
          end else if (lu_s) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_nop = 1'b1;
          end else begin
            pc_we     = 1'b0;
            if_id_nop = 1'b1;
          end
        end
        HALTED: begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          id_ex_we   = 1'b0;
          if_id_nop  = 1'b1;
          id_ex_nop  = 1'b1;
          ex_mem_nop = 1'b1;
          halted     = 1'b1;
        end
        default: begin
          pc_we = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_inc_s, flush_inc_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // A stall counts only when load-use actually wins arbitration.
  always_comb begin
    stall_inc_s = ((state_r == RUN) || (state_r == DRAIN)) && !ex_redirect && lu_s;
    flush_inc_s = (state_r == FLUSH) ||
                  (((state_r == RUN) || (state_r == DRAIN)) && ex_redirect);
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
